// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default depth,
// power-up memory contents and the byte-merge helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          DMEM_DEPTH = 32;
  localparam logic [31:0] INIT_WORD1 = 32'h0000_0054;
  localparam logic [31:0] INIT_WORD2 = 32'h0000_000B;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: combinational read, clocked byte-masked write.
// Contents are set at power-up only; reset never touches them.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_mask,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH] = '{1: INIT_WORD1, 2: INIT_WORD2, default: '0};

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= merge_bytes(r_mem[i_addr], i_wdata, i_mask);
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a
// held response. Define DMEM_STRB_EN to make writes honour req_strb.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = DMEM_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_accept;
  logic          w_access;
  logic          w_addr_err;
  logic          w_we;
  logic [3:0]    w_mask;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_mem_rdata;

  // Every request passes through WAIT; the counter runs down to zero there, so
  // the access edge always lands 1+WAIT_CYCLES edges after the accept edge.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept   = req_valid & req_ready;
  assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));
  assign w_idx      = r_addr[AW+1:2];
  assign w_we       = w_access & r_write & ~w_addr_err;

`ifdef DMEM_STRB_EN
  assign w_mask = r_strb;
`else
  logic w_unused_strb;
  assign w_mask        = 4'hF;
  assign w_unused_strb = ^r_strb;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_CYCLES);
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_strb  <= req_strb;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= (w_addr_err || r_write) ? 32'h0 : w_mem_rdata;
        r_err   <= w_addr_err;
      end else if (r_state == RESP && resp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_mask  (w_mask),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 4)
// checked against a word-array reference model; DMEM_STRB_EN selects byte writes.
module tb_dmem_responder;

`ifdef DMEM_STRB_EN
  localparam bit STRB_ON = 1'b1;
`else
  localparam bit STRB_ON = 1'b0;
`endif

  localparam int WC [3] = '{2, 0, 4};

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_strb   [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [3][32];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  dmem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_strb(req_strb[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_strb(req_strb[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  dmem_responder #(.WAIT_CYCLES(4)) u_dut_w4 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_strb(req_strb[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: a plain word array; errors leave it untouched.
  function automatic void model(input int k, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                output logic [31:0] rdata, output logic err);
    logic [31:0] idx;
    idx   = addr / 4;
    err   = (addr % 4 != 0) || (idx >= 32);
    rdata = 32'h0;
    if (!err) begin
      if (!wr) rdata = m_mem[k][idx[4:0]];
      else begin
        for (int b = 0; b < 4; b++) begin
          if (!STRB_ON || strb[b]) m_mem[k][idx[4:0]][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  endfunction

  task automatic check_reset_outputs(input int k, input string tag);
    check({tag, "_req_ready"},  32'(req_ready[k]),  32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata[k],      32'h0);
    check({tag, "_resp_err"},   32'(resp_err[k]),   32'd0);
  endtask

  task automatic txn(input int k, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                     output logic [31:0] rdata, output logic err);
    int n;
    bit got;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_write[k]  = wr;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_strb[k]   = strb;
    req_valid[k]  = 1'b1;
    resp_ready[k] = (hold == 0);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      if (resp_valid[k]) got = 1'b1;
      else begin
        check("req_ready_wait", 32'(req_ready[k]), 32'd0);
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("latency", 32'(n), 32'(1 + WC[k]));
    rdata = resp_rdata[k];
    err   = resp_err[k];
    if (!got) begin
      resp_ready[k] = 1'b0;
      return;
    end
    check("req_ready_resp", 32'(req_ready[k]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(resp_valid[k]), 32'd1);
      check("hold_rdata", resp_rdata[k], rdata);
      check("hold_err",   32'(resp_err[k]), 32'(err));
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    check("post_valid", 32'(resp_valid[k]), 32'd0);
    check("post_ready", 32'(req_ready[k]),  32'd1);
    check("post_rdata", resp_rdata[k],      32'h0);
    check("post_err",   32'(resp_err[k]),   32'd0);
  endtask

  task automatic txn_chk(input int k, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                         input string name);
    logic [31:0] rd, mrd;
    logic        er, mer;
    txn(k, wr, addr, wdata, strb, hold, rd, er);
    model(k, wr, addr, wdata, strb, mrd, mer);
    check({name, "_rdata"}, rd, mrd);
    check({name, "_err"}, 32'(er), 32'(mer));
  endtask

  // Start a request, let `edges` clock edges pass after the accept, then reset.
  task automatic abort(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int edges, input logic exp_valid);
    @(negedge clk);
    req_write[k]  = wr;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_strb[k]   = 4'hF;
    req_valid[k]  = 1'b1;
    resp_ready[k] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    repeat (edges) @(posedge clk);
    #1;
    check("abort_pre_valid", 32'(resp_valid[k]), 32'(exp_valid));
    #1;
    rst[k] = 1'b1;
    #1;
    check_reset_outputs(k, "abort");
    @(negedge clk);
    rst[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    logic [31:0] addr;
    int          sel;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_strb[k] = '0; resp_ready[k] = 1'b0;
      for (int w = 0; w < 32; w++) m_mem[k][w] = 32'h0;
      m_mem[k][1] = 32'h0000_0054;
      m_mem[k][2] = 32'h0000_000B;
    end

    vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,          4'hF, 32'h0000_0054, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,          4'hF, 32'h0000_000B, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF,  4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,          4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0006, 32'h0,          4'hF, 32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0080, 32'h0000_0001,  4'hF, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,          4'hF, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_007C, 32'h0,          4'hF, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h0000_007C, 32'hCAFE_F00D,  4'hF, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0000_007C, 32'h0,          4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          4'hF, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'h0000_0001, 32'h1234_5678,  4'hF, 32'h0,         1'b1};

    #3;
    check_reset_outputs(0, "reset");
    check_reset_outputs(1, "reset_w0");
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    for (int i = 0; i < 12; i++) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, rd, er);
      model(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 5, rd, er);
    check("backpressure_rdata", rd, 32'h0000_0054);
    check("backpressure_err", 32'(er), 32'd0);

    txn(0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0011, 0, rd, er);
    model(0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0011, mrd, mer);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er);
    check("strb_readback", rd, STRB_ON ? 32'h0000_CCDD : 32'hAABB_CCDD);
    txn_chk(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000, 1, "strb_zero_write");
    txn_chk(0, 1'b0, 32'h8, 32'h0, 4'hF, 0, "strb_zero_readback");

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      addr = 32'($urandom_range(0, 31)) * 4;
      else if (sel == 7) addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = 32'($urandom_range(32, 1000)) * 4;
      else               addr = $urandom;
      txn_chk(0, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), "rand");
    end

    txn_chk(1, 1'b0, 32'h4, 32'h0, 4'hF, 0, "w0_read");
    txn_chk(1, 1'b1, 32'h14, 32'h5A5A_0001, 4'hF, 2, "w0_write");
    txn_chk(1, 1'b0, 32'h14, 32'h0, 4'hF, 0, "w0_readback");
    abort(1, 1'b1, 32'h18, 32'h1234_5678, 1, 1'b1);
    model(1, 1'b1, 32'h18, 32'h1234_5678, 4'hF, mrd, mer);
    txn(1, 1'b0, 32'h18, 32'h0, 4'hF, 0, rd, er);
    check("resp_reset_commit", rd, 32'h1234_5678);

    txn_chk(2, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 0, "w4_write");
    abort(2, 1'b1, 32'h10, 32'h3333_4444, 2, 1'b0);
    txn(2, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("wait_reset_lost", rd, 32'h1111_2222);
    check("wait_reset_err", 32'(er), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
